// File: rtl/host_arb.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// host_arb
// Round-robin arbiter that lets NREQ requesters burst 16-bit words into the
// write side (port B) of a shared host FIFO. A burst is only granted when it
// fits entirely in the FIFO space left since the host last drained it, so the
// FIFO can never overflow and no requester is ever partially served.
//
// Ports
//   i_hb_clk      sole clock, rising edge
//   i_hb_rst      asynchronous active-high reset
//   i_req         per-requester burst request (level, held until o_done)
//   i_req_len     per-requester burst length in words, LEN_W bits per lane
//   i_din         per-requester data word, 16 bits per lane
//   i_host_rst    host drained the FIFO; clears the fill count
//   o_gnt         one-hot registered grant
//   o_rd_strobe   one pulse per word consumed from the owning requester
//   o_hb_wr       FIFO port-B write strobe
//   o_hb_din      FIFO port-B write data (zero when not writing)
//   o_busy        arbiter is not idle
//   o_done        one-cycle pulse at the end of each burst
//   o_fill        words written since the last host drain
// -----------------------------------------------------------------------------
module host_arb #(
   parameter int NREQ  = 4,
   parameter int BUF_W = 2048,
   parameter int LEN_W = 12
) (
   input  logic                  i_hb_clk,
   input  logic                  i_hb_rst,
   input  logic [NREQ-1:0]       i_req,
   input  logic [NREQ*LEN_W-1:0] i_req_len,
   input  logic [NREQ*16-1:0]    i_din,
   input  logic                  i_host_rst,
   output logic [NREQ-1:0]       o_gnt,
   output logic [NREQ-1:0]       o_rd_strobe,
   output logic                  o_hb_wr,
   output logic [15:0]           o_hb_din,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [LEN_W-1:0]      o_fill
);

   localparam int RR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_XFER  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]       r_state;
   logic [NREQ-1:0]  r_gnt;
   logic [RR_W-1:0]  r_owner;
   logic [LEN_W-1:0] r_cnt;
   logic [LEN_W-1:0] r_fill;
   logic [RR_W-1:0]  r_rr;
   logic             r_rst_pend;   // host drain seen mid-burst, applied at burst end

   logic [LEN_W-1:0] w_len_arr [NREQ];
   logic [15:0]      w_din_arr [NREQ];
   logic [NREQ-1:0]  w_elig;
   logic [LEN_W:0]   w_space;
   logic             w_found;
   logic [RR_W-1:0]  w_winner;
   logic [RR_W-1:0]  w_idx;
   logic [RR_W-1:0]  w_rr_next;
   logic             w_wr;

   // One extra bit so BUF_W - fill is exact even when LEN_W only just holds BUF_W.
   assign w_space = (LEN_W+1)'(BUF_W) - {1'b0, r_fill};

   for (genvar i = 0; i < NREQ; i++) begin : g_lane
      assign w_len_arr[i] = i_req_len[i*LEN_W +: LEN_W];
      assign w_din_arr[i] = i_din[i*16 +: 16];
      // A burst that does not fit the remaining space waits whole; a length
      // larger than the FIFO therefore never becomes eligible.
      assign w_elig[i]    = i_req[i] && ({1'b0, w_len_arr[i]} <= w_space);
   end

   // Winner is the first eligible requester at or after the round-robin pointer.
   always_comb begin
      // NOTE: every variable assigned here gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      w_found  = 1'b0;
      w_winner = '0;
      w_idx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = RR_W'((int'(r_rr) + k) % NREQ);
         if (!w_found && w_elig[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
   end

   assign w_rr_next = (r_owner == RR_W'(NREQ-1)) ? '0 : r_owner + 1'b1;

   // Write path is combinational from state and owner so data lands in the
   // same cycle the requester sees its read strobe.
   assign w_wr        = (r_state == S_XFER);
   assign o_hb_wr     = w_wr;
   assign o_hb_din    = w_wr ? w_din_arr[r_owner] : 16'h0000;
   assign o_rd_strobe = w_wr ? (NREQ'(1) << r_owner) : '0;
   assign o_gnt       = r_gnt;
   assign o_busy      = (r_state != S_IDLE);
   assign o_done      = (r_state == S_DONE);
   assign o_fill      = r_fill;

   always_ff @(posedge i_hb_clk or posedge i_hb_rst) begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (i_hb_rst) begin
         r_state    <= S_IDLE;
         r_gnt      <= '0;
         r_owner    <= '0;
         r_cnt      <= '0;
         r_fill     <= '0;
         r_rr       <= '0;
         r_rst_pend <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // Eligibility above still uses the pre-drain fill; the cleared
               // count takes effect from the next arbitration.
               if (i_host_rst) begin
                  r_fill <= '0;
               end
               if (w_found) begin
                  r_state <= S_GRANT;
                  r_owner <= w_winner;
                  r_cnt   <= w_len_arr[w_winner];
                  r_gnt   <= NREQ'(1) << w_winner;
               end
            end
            S_GRANT: begin
               if (i_host_rst) begin
                  r_rst_pend <= 1'b1;
               end
               r_state <= (r_cnt != '0) ? S_XFER : S_DONE;
            end
            S_XFER: begin
               if (i_host_rst) begin
                  r_rst_pend <= 1'b1;
               end
               r_fill <= r_fill + 1'b1;
               r_cnt  <= r_cnt - 1'b1;
               if (r_cnt == LEN_W'(1)) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               // A drain requested during the burst clears everything written,
               // including the burst that was in flight.
               if (r_rst_pend || i_host_rst) begin
                  r_fill <= '0;
               end
               r_rst_pend <= 1'b0;
               r_gnt      <= '0;
               r_rr       <= w_rr_next;
               r_state    <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_host_arb.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_host_arb
// Self-checking bench for host_arb: a directed cycle table, hand-written
// multi-cycle corner sequences, and randomized traffic compared against a
// burst-timeline reference model.
// -----------------------------------------------------------------------------
module tb_host_arb;

   localparam int NREQ  = 4;
   localparam int BUF_W = 2048;
   localparam int LEN_W = 12;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*LEN_W-1:0] req_len;
   logic [NREQ*16-1:0]    din;
   logic                  host_rst;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       rd_strobe;
   logic                  hb_wr;
   logic [15:0]           hb_din;
   logic                  busy;
   logic                  done;
   logic [LEN_W-1:0]      fill;

   host_arb #(.NREQ(NREQ), .BUF_W(BUF_W), .LEN_W(LEN_W)) dut (
      .i_hb_clk    (clk),
      .i_hb_rst    (rst),
      .i_req       (req),
      .i_req_len   (req_len),
      .i_din       (din),
      .i_host_rst  (host_rst),
      .o_gnt       (gnt),
      .o_rd_strobe (rd_strobe),
      .o_hb_wr     (hb_wr),
      .o_hb_din    (hb_din),
      .o_busy      (busy),
      .o_done      (done),
      .o_fill      (fill)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Stimulus held per lane, packed onto the ports by apply().
   int          lens  [NREQ];
   logic [15:0] dlane [NREQ];

   task automatic apply();
      for (int i = 0; i < NREQ; i++) begin
         req_len[i*LEN_W +: LEN_W] = LEN_W'(lens[i]);
         din[i*16 +: 16]           = dlane[i];
      end
   endtask

   task automatic rand_din();
      for (int i = 0; i < NREQ; i++) dlane[i] = 16'($urandom);
   endtask

   // ---------------- reference model: a burst is a timeline ----------------
   // pos 1 = grant cycle, pos 2..len+1 = write cycles, pos len+2 = done cycle.
   bit m_active;
   int m_pos, m_len, m_owner, m_fill, m_rr;
   bit m_pend;

   int e_gnt, e_rd, e_wr, e_din, e_busy, e_done, e_fill;
   int s_gnt, s_rd, s_wr, s_din, s_busy, s_done, s_fill;

   task automatic model_reset();
      m_active = 0; m_pos = 0; m_len = 0; m_owner = 0;
      m_fill = 0; m_rr = 0; m_pend = 0;
   endtask

   task automatic model_out();
      e_busy = m_active;
      e_gnt  = m_active ? (1 << m_owner) : 0;
      e_wr   = (m_active && m_pos >= 2 && m_pos <= m_len + 1) ? 1 : 0;
      e_din  = e_wr ? int'(dlane[m_owner]) : 0;
      e_rd   = e_wr ? (1 << m_owner) : 0;
      e_done = (m_active && m_pos == m_len + 2) ? 1 : 0;
      e_fill = m_fill;
   endtask

   task automatic model_step();
      if (!m_active) begin
         int old_fill;
         old_fill = m_fill;
         if (host_rst) m_fill = 0;
         for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_rr + k) % NREQ;
            if (req[idx] && lens[idx] <= BUF_W - old_fill) begin
               m_active = 1; m_pos = 1; m_owner = idx; m_len = lens[idx];
               break;
            end
         end
      end else begin
         if (e_wr != 0) m_fill++;
         if (host_rst) m_pend = 1;
         if (m_pos == m_len + 2) begin
            m_active = 0;
            m_rr     = (m_owner + 1) % NREQ;
            if (m_pend) m_fill = 0;
            m_pend   = 0;
         end else begin
            m_pos++;
         end
      end
   endtask

   // One clock cycle: inputs are already set at a falling edge; outputs are
   // sampled 1 ns later, the model advances, then wait for the next falling edge.
   task automatic step(input bit use_model);
      apply();
      #1;
      if (rst) model_reset();
      model_out();
      s_gnt = int'(gnt); s_rd = int'(rd_strobe); s_wr = int'(hb_wr);
      s_din = int'(hb_din); s_busy = int'(busy); s_done = int'(done);
      s_fill = int'(fill);
      if (use_model) begin
         check("gnt",       s_gnt,  e_gnt);
         check("rd_strobe", s_rd,   e_rd);
         check("hb_wr",     s_wr,   e_wr);
         check("hb_din",    s_din,  e_din);
         check("busy",      s_busy, e_busy);
         check("done",      s_done, e_done);
         check("fill",      s_fill, e_fill);
      end
      if (!rst) model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; host_rst = 1'b0;
      for (int i = 0; i < NREQ; i++) begin lens[i] = 0; dlane[i] = 16'h0; end
      step(1);
      rst = 1'b0;
   endtask

   function automatic int onehot_idx(input int g);
      for (int i = 0; i < NREQ; i++) if (g[i]) return i;
      return -1;
   endfunction

   // ---------------- directed cycle table ----------------
   typedef struct {
      logic [3:0]  req;
      int          len;
      logic [15:0] d;
      logic [3:0]  gnt;
      logic        wr;
      logic [15:0] hd;
      logic [3:0]  rd;
      logic        done;
      logic        busy;
      int          fill;
   } vec_t;

   vec_t tbl [7];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int owners [5];
      int times  [5];
      int n, prev, writes, wpred, gseen;
      bit seen;
      bit last_done;
      int last_gnt;

      // Requester 2, three words A,B,C: grant cycle 1, writes 2-4, done 5.
      tbl[0] = '{4'b0100, 3, 16'h0000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 0};
      tbl[1] = '{4'b0100, 3, 16'h0000, 4'b0100, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b1, 0};
      tbl[2] = '{4'b0100, 3, 16'hA1A1, 4'b0100, 1'b1, 16'hA1A1, 4'b0100, 1'b0, 1'b1, 0};
      tbl[3] = '{4'b0100, 3, 16'hB2B2, 4'b0100, 1'b1, 16'hB2B2, 4'b0100, 1'b0, 1'b1, 1};
      tbl[4] = '{4'b0100, 3, 16'hC3C3, 4'b0100, 1'b1, 16'hC3C3, 4'b0100, 1'b0, 1'b1, 2};
      tbl[5] = '{4'b0100, 3, 16'h0000, 4'b0100, 1'b0, 16'h0000, 4'b0000, 1'b1, 1'b1, 3};
      tbl[6] = '{4'b0000, 3, 16'h0000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 3};

      rst = 1'b1; req = '0; host_rst = 1'b0; req_len = '0; din = '0;
      @(negedge clk);

      // Reset values.
      do_reset();
      check("rst_gnt",  s_gnt,  0);
      check("rst_busy", s_busy, 0);
      check("rst_fill", s_fill, 0);
      check("rst_wr",   s_wr,   0);

      for (int r = 0; r < 7; r++) begin
         req = tbl[r].req;
         for (int i = 0; i < NREQ; i++) begin
            lens[i]  = tbl[r].len;
            dlane[i] = (i == 2) ? tbl[r].d : 16'hBAD0 + 16'(i);
         end
         step(0);
         check($sformatf("tbl%0d_gnt", r),  s_gnt,  int'(tbl[r].gnt));
         check($sformatf("tbl%0d_wr", r),   s_wr,   int'(tbl[r].wr));
         check($sformatf("tbl%0d_din", r),  s_din,  int'(tbl[r].hd));
         check($sformatf("tbl%0d_rd", r),   s_rd,   int'(tbl[r].rd));
         check($sformatf("tbl%0d_done", r), s_done, int'(tbl[r].done));
         check($sformatf("tbl%0d_busy", r), s_busy, int'(tbl[r].busy));
         check($sformatf("tbl%0d_fill", r), s_fill, tbl[r].fill);
      end

      // All four requesting length 1: round robin 0,1,2,3,0, four cycles apart.
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < NREQ; i++) lens[i] = 1;
      n = 0; prev = 0;
      for (int c = 0; c < 40 && n < 5; c++) begin
         rand_din();
         step(1);
         if (s_gnt != 0 && prev == 0) begin
            owners[n] = onehot_idx(s_gnt);
            times[n]  = c;
            n++;
         end
         prev = s_gnt;
      end
      check("rr_grants", n, 5);
      for (int i = 0; i < 5; i++) if (i < n) check($sformatf("rr_owner%0d", i), owners[i], i % NREQ);
      for (int i = 1; i < 5; i++) if (i < n) check($sformatf("rr_gap%0d", i), times[i] - times[i-1], 4);

      // Near-full FIFO: only the burst that fits is served until the host drains.
      do_reset();
      req = 4'b1000; lens[3] = 2040;
      seen = 0;
      for (int c = 0; c < 2100; c++) begin
         rand_din(); step(1);
         if (s_done != 0) begin seen = 1; break; end
      end
      check("fill2040_done", seen, 1);
      req = 4'b0000;
      step(1);
      check("fill2040", s_fill, 2040);
      req = 4'b0011; lens[0] = 16; lens[1] = 8;
      gseen = 0;
      for (int c = 0; c < 5; c++) begin
         rand_din(); step(1);
         if (s_gnt != 0) begin gseen = s_gnt; break; end
      end
      check("fit_grant", gseen, 4'b0010);
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         rand_din(); step(1);
         if (s_done != 0) begin seen = 1; break; end
      end
      check("fit_done", seen, 1);
      req = 4'b0001;
      for (int c = 0; c < 4; c++) step(1);
      check("full_wait_gnt", s_gnt, 0);
      check("full_fill", s_fill, 2048);
      host_rst = 1'b1; step(1); host_rst = 1'b0;
      step(1);
      check("drain_fill", s_fill, 0);
      check("drain_nogrant_yet", s_gnt, 0);
      step(1);
      check("drain_grant0", s_gnt, 4'b0001);

      // Host drain in the middle of a 10-word burst.
      do_reset();
      req = 4'b0001; lens[0] = 10;
      writes = 0; wpred = 0; seen = 0;
      for (int c = 0; c < 30; c++) begin
         rand_din();
         model_out();
         if (e_wr != 0) wpred++;
         host_rst = (e_wr != 0 && wpred == 4);
         step(1);
         host_rst = 1'b0;
         if (s_wr != 0) writes++;
         if (s_done != 0) begin seen = 1; break; end
      end
      check("mid_drain_done", seen, 1);
      check("mid_drain_writes", writes, 10);
      check("mid_drain_fill_at_done", s_fill, 10);
      req = 4'b0000;
      step(1);
      check("mid_drain_fill_after", s_fill, 0);

      // Zero-length burst: no writes, a done pulse, pointer still advances.
      do_reset();
      req = 4'b0010; lens[1] = 0;
      writes = 0; seen = 0; gseen = 0;
      for (int c = 0; c < 10; c++) begin
         step(1);
         if (s_wr != 0) writes++;
         if (s_gnt == 4'b0010) gseen = 1;
         if (s_done != 0) begin seen = 1; break; end
      end
      check("zlen_done", seen, 1);
      check("zlen_writes", writes, 0);
      check("zlen_gnt_seen", gseen, 1);
      req = 4'b0000;
      step(1);
      check("zlen_gnt_cleared", s_gnt, 0);
      req = 4'b0110; lens[1] = 1; lens[2] = 1;
      step(1);
      step(1);
      check("zlen_rr_adv", s_gnt, 4'b0100);

      // Reset in the middle of a transfer.
      do_reset();
      req = 4'b0100; lens[2] = 5;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         rand_din(); step(1);
         if (s_wr != 0) begin seen = 1; break; end
      end
      check("xfer_reached", seen, 1);
      step(1);
      rst = 1'b1;
      step(1);
      check("abort_wr",   s_wr,   0);
      check("abort_gnt",  s_gnt,  0);
      check("abort_busy", s_busy, 0);
      check("abort_din",  s_din,  0);
      check("abort_rd",   s_rd,   0);
      check("abort_fill", s_fill, 0);
      rst = 1'b0;
      req = 4'b0110; lens[1] = 2; lens[2] = 2;
      gseen = 0;
      for (int c = 0; c < 5; c++) begin
         step(1);
         if (s_gnt != 0) begin gseen = s_gnt; break; end
      end
      check("abort_next_grant", gseen, 4'b0010);

      // Randomized traffic against the model.
      do_reset();
      last_done = 0; last_gnt = 0;
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (req[i]) begin
               if (last_done && last_gnt[i]) req[i] = 1'b0;
               else if (m_active && m_owner == i && $urandom_range(0, 15) == 0) req[i] = 1'b0;
               else if ($urandom_range(0, 199) == 0) req[i] = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
               int pick;
               pick = $urandom_range(0, 15);
               req[i] = 1'b1;
               if (pick == 0)      lens[i] = 0;
               else if (pick == 1) lens[i] = 3000;
               else if (pick < 4)  lens[i] = $urandom_range(100, 700);
               else                lens[i] = $urandom_range(1, 8);
            end
         end
         rand_din();
         host_rst = ($urandom_range(0, 59) == 0);
         rst      = ($urandom_range(0, 799) == 0);
         step(1);
         last_done = (e_done != 0);
         last_gnt  = e_gnt;
      end
      rst = 1'b0; host_rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/host_arb.md
HOST_ARB -- requirements
Module: host_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing host FIFO port B.
REQ-002 Parameter BUF_W, default 2048, host FIFO depth in 16-bit words.
REQ-003 Parameter LEN_W, default 12, burst-length field width; SHALL be wide enough to hold BUF_W.
REQ-004 hb_clk  in  1  sole clock; all logic rising-edge.
REQ-005 hb_rst  in  1  asynchronous, active-high reset.
REQ-006 req  in  NREQ  per-requester burst request, level; held until done.
REQ-007 req_len  in  NREQ*LEN_W  per-requester burst length in words, sampled at grant.
REQ-008 din  in  NREQ*16  per-requester data word, valid while granted.
REQ-009 host_rst  in  1  host drained FIFO; clears fill count.
REQ-010 gnt  out  NREQ  one-hot grant, registered.
REQ-011 rd_strobe  out  NREQ  one-cycle pulse per word consumed from owner.
REQ-012 hb_wr  out  1  FIFO port-B write strobe.
REQ-013 hb_din  out  16  FIFO port-B write data.
REQ-014 busy  out  1  high in any state except IDLE.
REQ-015 done  out  1  one-cycle pulse at burst end.
REQ-016 fill  out  LEN_W  words written since last host_rst.

Function
REQ-017 States: IDLE, GRANT, XFER, DONE; encoding is implementer's choice.
REQ-018 Eligible requester: req high and req_len <= BUF_W - fill.
REQ-019 IDLE: any eligible -> GRANT; winner = first eligible at or after rr pointer, wrapping NREQ-1 -> 0.
REQ-020 GRANT entry: gnt[winner]=1, owner and cnt=req_len[owner] latched; ineligible requesters wait, never partially served.
REQ-021 GRANT -> XFER if cnt != 0; cnt == 0 -> DONE with zero writes.
REQ-022 XFER, each cycle: hb_wr=1, hb_din=din[owner], rd_strobe[owner]=1, cnt-1, fill+1; cnt==1 is last write -> DONE.
REQ-023 hb_wr, hb_din and rd_strobe are combinational from state/owner (same cycle); hb_din = 0 when hb_wr low.
REQ-024 DONE: done=1, gnt cleared on exit, rr = owner+1 modulo NREQ, -> IDLE.
REQ-025 Burst of N>0 words: N hb_wr cycles contiguous, first write 2 cycles after req sampled in IDLE, done on cycle N+2.
REQ-026 req deasserting during GRANT/XFER does not abort; burst completes.
REQ-027 host_rst in IDLE: fill=0 next cycle. In any other state: latched pending, fill cleared on DONE->IDLE transition; writes of the in-flight burst are included in the clear.
REQ-028 fill never exceeds BUF_W; eligibility check guarantees no overflow, no wrap.
REQ-029 req_len > BUF_W: requester never eligible (starves until host sizes it down); no error output.
REQ-030 Arbitration is never re-evaluated mid-burst; new requests wait for IDLE.

Reset
REQ-031 hb_rst: state=IDLE, gnt=0, rd_strobe=0, hb_wr=0, hb_din=0, busy=0, done=0, fill=0, rr=0, cnt=0, host_rst pending=0.
REQ-032 hb_rst mid-burst aborts immediately; remaining words are not written, no done pulse.
REQ-033 First arbitration after reset favours requester 0.

Verification
REQ-034 req[2]=1, len=3, din=A,B,C -> gnt[2] at cycle 1, hb_wr cycles 2-4 with A,B,C, done cycle 5, fill=3.
REQ-035 req=4'b1111 all len=1, held -> grants 0,1,2,3,0 order, one write each, 4 cycles per burst.
REQ-036 fill=2040, req[0] len=16, req[1] len=8 -> requester 1 granted, requester 0 waits; host_rst -> fill=0, then requester 0 granted.
REQ-037 host_rst pulsed mid-burst (len=10, pulse at write 4) -> all 10 written; fill=0 the cycle after done.
REQ-038 req_len=0 -> gnt one cycle, no hb_wr, done pulse, rr advances.
REQ-039 hb_rst asserted during XFER -> all outputs 0 immediately; next req served from requester 0 onward.
